// File: rtl/vga_control.sv
// rtl/vga_control.sv - VGA 640x480@60 timing generator with eight-bar colour test pattern
// Pixel rate is clk/2 via a toggling enable; all outputs are registered from the counters.
module vga_control #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [7:0] vga_rgb
);

  localparam logic [9:0] L_H_LAST  = 10'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] L_V_LAST  = 10'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] L_HS_END  = 10'(H_SYNC);
  localparam logic [9:0] L_VS_END  = 10'(V_SYNC);
  localparam logic [9:0] L_HA_BEG  = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] L_HA_END  = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] L_VA_BEG  = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] L_VA_END  = 10'(V_SYNC + V_BACK + V_ACTIVE);

  logic       r_pix_en;
  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  logic       r_hs;
  logic       r_vs;
  logic [7:0] r_rgb;

  logic [9:0] w_x;
  logic [2:0] w_bar;
  logic       w_active;
  logic [7:0] w_colour;

  assign w_x      = r_hcnt - L_HA_BEG;
  assign w_bar    = 3'(w_x / 10'd80);
  assign w_active = (r_hcnt >= L_HA_BEG) && (r_hcnt < L_HA_END) &&
                    (r_vcnt >= L_VA_BEG) && (r_vcnt < L_VA_END);

  always_comb begin
    w_colour = 8'h00;
    case (w_bar)
      3'd0:    w_colour = 8'hFF;
      3'd1:    w_colour = 8'hFC;
      3'd2:    w_colour = 8'h1F;
      3'd3:    w_colour = 8'h1C;
      3'd4:    w_colour = 8'hE3;
      3'd5:    w_colour = 8'hE0;
      3'd6:    w_colour = 8'h03;
      default: w_colour = 8'h00;
    endcase
  end

  // rst_n is active-high despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_pix_en <= 1'b0;
      r_hcnt   <= '0;
      r_vcnt   <= '0;
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
      r_rgb    <= 8'h00;
    end else begin
      r_pix_en <= ~r_pix_en;
      if (r_pix_en) begin
        if (r_hcnt == L_H_LAST) begin
          r_hcnt <= '0;
          r_vcnt <= (r_vcnt == L_V_LAST) ? 10'd0 : r_vcnt + 10'd1;
        end else begin
          r_hcnt <= r_hcnt + 10'd1;
        end
      end
      r_hs  <= (r_hcnt >= L_HS_END);
      r_vs  <= (r_vcnt >= L_VS_END);
      r_rgb <= w_active ? w_colour : 8'h00;
    end
  end

  assign vga_hs  = r_hs;
  assign vga_vs  = r_vs;
  assign vga_rgb = r_rgb;

endmodule

// File: tb/tb_vga_control.sv
// tb/tb_vga_control.sv - self-checking bench for vga_control
// Vertical timing is shortened so whole frames fit in a short run; horizontal timing is the real 800-pixel line.
module tb_vga_control;

  localparam int VS = 2, VB = 3, VA = 4, VF = 2;
  localparam int VT = VS + VB + VA + VF;
  localparam int HT = 800;
  localparam int FRAME_CLK = 2 * HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vga_hs;
  logic       vga_vs;
  logic [7:0] vga_rgb;

  int checks = 0;
  int errors = 0;

  int         spot_x[10] = '{0, 80, 160, 240, 320, 400, 480, 560, 79, 639};
  logic [7:0] spot_c[10] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00, 8'hFF, 8'h00};

  always #10 clk = ~clk;

  vga_control #(
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .vga_hs (vga_hs),
    .vga_vs (vga_vs),
    .vga_rgb(vga_rgb)
  );

  function automatic logic [7:0] bar_col(input int b);
    case (b)
      0: return 8'hFF;
      1: return 8'hFC;
      2: return 8'h1F;
      3: return 8'h1C;
      4: return 8'hE3;
      5: return 8'hE0;
      6: return 8'h03;
      default: return 8'h00;
    endcase
  endfunction

  // t = number of rising clk edges since reset release (first edge is t = 1)
  function automatic void model(input int t, output logic hs, output logic vs, output logic [7:0] rgb);
    int p, h, v;
    p   = (t - 1) / 2;
    h   = p % HT;
    v   = (p / HT) % VT;
    hs  = (h >= 96);
    vs  = (v >= VS);
    rgb = (h >= 144 && h < 784 && v >= VS + VB && v < VS + VB + VA) ? bar_col((h - 144) / 80) : 8'h00;
  endfunction

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({vga_hs, vga_vs, vga_rgb} !== 10'b11_0000_0000) begin
        errors++;
        $display("FAIL reset_hold: got hs=%b vs=%b rgb=%h, want hs=1 vs=1 rgb=00", vga_hs, vga_vs, vga_rgb);
      end
    end
  endtask

  task automatic test_async_reset();
    logic hs, vs;
    logic [7:0] rgb;
    for (int k = 0; k < 3; k++) begin
      int n;
      n = $urandom_range(200, 3000);
      release_reset();
      repeat (n) @(posedge clk);
      #1;
      model(n, hs, vs, rgb);
      checks++;
      if ({vga_hs, vga_vs, vga_rgb} !== {hs, vs, rgb}) begin
        errors++;
        $display("FAIL pre_reset_state t=%0d: got %b %b %h, want %b %b %h", n, vga_hs, vga_vs, vga_rgb, hs, vs, rgb);
      end
      #2 rst_n = 1'b1;
      #2;
      checks++;
      if ({vga_hs, vga_vs, vga_rgb} !== 10'b11_0000_0000) begin
        errors++;
        $display("FAIL async_reset t=%0d: got hs=%b vs=%b rgb=%h, want hs=1 vs=1 rgb=00", n, vga_hs, vga_vs, vga_rgb);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_timing();
    int   hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$];
    logic prev_hs, prev_vs, hs, vs;
    logic [7:0] rgb;
    int   n_clk, p, h, v;
    n_clk = 2 * FRAME_CLK + 400;
    release_reset();
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    for (int t = 1; t <= n_clk; t++) begin
      @(posedge clk);
      @(negedge clk);
      model(t, hs, vs, rgb);
      checks++;
      if ({vga_hs, vga_vs, vga_rgb} !== {hs, vs, rgb}) begin
        errors++;
        $display("FAIL model t=%0d: got hs=%b vs=%b rgb=%h, want hs=%b vs=%b rgb=%h", t, vga_hs, vga_vs, vga_rgb, hs, vs, rgb);
      end
      p = (t - 1) / 2;
      h = p % HT;
      v = (p / HT) % VT;
      if (v == VS + VB) begin
        for (int s = 0; s < 10; s++) begin
          if (h == 144 + spot_x[s]) begin
            checks++;
            if (vga_rgb !== spot_c[s]) begin
              errors++;
              $display("FAIL colour_bar x=%0d t=%0d: got %h, want %h", spot_x[s], t, vga_rgb, spot_c[s]);
            end
          end
        end
      end
      if (t == FRAME_CLK + 1 || t == 2 * FRAME_CLK + 1) begin
        checks++;
        if ({prev_hs, prev_vs, vga_hs, vga_vs} !== 4'b1100) begin
          errors++;
          $display("FAIL frame_wrap t=%0d: got prev hs/vs=%b%b now hs/vs=%b%b, want 11 then 00", t, prev_hs, prev_vs, vga_hs, vga_vs);
        end
      end
      if (prev_vs !== vga_vs) begin
        checks++;
        if (!(prev_hs === 1'b1 && vga_hs === 1'b0)) begin
          errors++;
          $display("FAIL vs_hs_align t=%0d: got hs %b->%b at vs edge, want 1->0", t, prev_hs, vga_hs);
        end
      end
      if (prev_hs === 1'b1 && vga_hs === 1'b0) hs_fall.push_back(t);
      if (prev_hs === 1'b0 && vga_hs === 1'b1) hs_rise.push_back(t);
      if (prev_vs === 1'b1 && vga_vs === 1'b0) vs_fall.push_back(t);
      if (prev_vs === 1'b0 && vga_vs === 1'b1) vs_rise.push_back(t);
      prev_hs = vga_hs;
      prev_vs = vga_vs;
    end

    checks++;
    if (hs_fall.size() != 23 || vs_fall.size() != 3) begin
      errors++;
      $display("FAIL edge_count: got hs falls=%0d vs falls=%0d, want 23 and 3", hs_fall.size(), vs_fall.size());
    end
    checks++;
    if (hs_fall.size() == 0 || hs_fall[0] != 1) begin
      errors++;
      $display("FAIL first_hs_fall: got t=%0d, want t=1", (hs_fall.size() == 0) ? -1 : hs_fall[0]);
    end
    for (int i = 1; i < hs_fall.size(); i++) begin
      checks++;
      if (hs_fall[i] - hs_fall[i-1] != 1600) begin
        errors++;
        $display("FAIL hs_period line=%0d: got %0d clk, want 1600", i, hs_fall[i] - hs_fall[i-1]);
      end
    end
    for (int i = 0; i < hs_rise.size() && i < hs_fall.size(); i++) begin
      checks++;
      if (hs_rise[i] - hs_fall[i] != 192) begin
        errors++;
        $display("FAIL hs_low_width line=%0d: got %0d clk, want 192", i, hs_rise[i] - hs_fall[i]);
      end
    end
    for (int i = 1; i < vs_fall.size(); i++) begin
      checks++;
      if (vs_fall[i] - vs_fall[i-1] != FRAME_CLK) begin
        errors++;
        $display("FAIL vs_period frame=%0d: got %0d clk, want %0d", i, vs_fall[i] - vs_fall[i-1], FRAME_CLK);
      end
    end
    for (int i = 0; i < vs_rise.size() && i < vs_fall.size(); i++) begin
      checks++;
      if (vs_rise[i] - vs_fall[i] != 2 * HT * VS) begin
        errors++;
        $display("FAIL vs_low_width frame=%0d: got %0d clk, want %0d", i, vs_rise[i] - vs_fall[i], 2 * HT * VS);
      end
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_timing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
